// File: rtl/page_switch_ctrl.sv
// Page sequencer for the VGA page-select multiplexer.
// Debounces the next/previous matrix keys, edge-detects the PS2 space key,
// and switches page only on a frame boundary followed by a run of blanked frames.
module page_switch_ctrl #(
  parameter int NUM_PAGES    = 4,
  parameter int PAGE_W       = 2,
  parameter int DB_CYCLES    = 1000000,
  parameter int BLANK_FRAMES = 2,
  parameter int RESET_PAGE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          btns,
  input  logic [4:0]           ps2_keys,
  input  logic                 v_sync,
  output logic [PAGE_W-1:0]    page_sel,
  output logic [NUM_PAGES-1:0] page_en,
  output logic                 blank,
  output logic                 busy
);

  // The debounce counter only has to reach DB_CYCLES-1 before the state flips.
  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // The frame counter holds 0..BLANK_FRAMES-1; the increment carries one extra bit.
  localparam int CNT_W = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES);
  localparam logic [CNT_W:0] CNT_DONE = (CNT_W + 1)'(BLANK_FRAMES);

  localparam logic [PAGE_W-1:0]    LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
  localparam logic [PAGE_W-1:0]    RESET_SEL  = PAGE_W'(RESET_PAGE);
  localparam logic [NUM_PAGES-1:0] RESET_EN   = NUM_PAGES'(1) << RESET_PAGE;

  typedef enum logic [1:0] {
    SHOW,
    PENDING,
    BLANK
  } state_t;

  logic [1:0]      btn_s1;
  logic [1:0]      btn_s2;
  logic [1:0]      db_state;
  logic [1:0]      db_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic            space_prev;
  logic            vs_s1;
  logic            vs_s2;
  logic            vs_prev;

  logic            next_raw;
  logic            prev_raw;
  logic            next_req;
  logic            prev_req;
  logic            fb;

  state_t            state;
  state_t            state_n;
  logic [PAGE_W-1:0] target;
  logic [PAGE_W-1:0] target_n;
  logic [PAGE_W-1:0] page_n;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W:0]    cnt_inc;
  logic [NUM_PAGES-1:0] page_en_n;
  logic              blank_n;
  logic              busy_n;

  // Keys other than next/previous/space are wired in but intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{btns[15:2], ps2_keys[3:0]};

  // Two-flop synchronisers for the asynchronous keys and the vga_clk-domain sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
    end else begin
      btn_s1 <= btns[1:0];
      btn_s2 <= btn_s1;
      vs_s1  <= v_sync;
      vs_s2  <= vs_s1;
    end
  end

  // Each key's debounced level only follows the raw level after it has differed for DB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_state  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] != db_state[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_state[i] <= btn_s2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous-cycle copies used to turn levels into one-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev    <= '0;
      space_prev <= 1'b0;
      vs_prev    <= 1'b0;
    end else begin
      db_prev    <= db_state;
      space_prev <= ps2_keys[4];
      vs_prev    <= vs_s2;
    end
  end

  // Contradictory simultaneous requests cancel each other out.
  assign next_raw = (db_state[0] & ~db_prev[0]) | (ps2_keys[4] & ~space_prev);
  assign prev_raw = db_state[1] & ~db_prev[1];
  assign next_req = next_raw & ~prev_raw;
  assign prev_req = prev_raw & ~next_raw;
  assign fb       = vs_prev & ~vs_s2;
  assign cnt_inc  = {1'b0, frame_cnt} + (CNT_W + 1)'(1);

  // Next-state logic; outputs are derived from the next state so they can be registered together.
  always_comb begin
    state_n   = state;
    page_n    = page_sel;
    target_n  = target;
    cnt_n     = frame_cnt;
    page_en_n = '0;
    blank_n   = 1'b0;
    busy_n    = 1'b0;

    case (state)
      SHOW: begin
        if (next_req) begin
          target_n = (page_sel == LAST_PAGE) ? '0 : page_sel + PAGE_W'(1);
          state_n  = PENDING;
        end else if (prev_req) begin
          target_n = (page_sel == '0) ? LAST_PAGE : page_sel - PAGE_W'(1);
          state_n  = PENDING;
        end
      end
      PENDING: begin
        if (fb) begin
          page_n  = target;
          cnt_n   = '0;
          state_n = (BLANK_FRAMES == 0) ? SHOW : BLANK;
        end
      end
      BLANK: begin
        if (fb) begin
          cnt_n = cnt_inc[CNT_W-1:0];
          if (cnt_inc == CNT_DONE) begin
            state_n = SHOW;
          end
        end
      end
      default: begin
        state_n = SHOW;
      end
    endcase

    busy_n  = (state_n != SHOW);
    blank_n = (state_n == BLANK);
    if (state_n == SHOW) begin
      page_en_n = NUM_PAGES'(1) << page_n;
    end
  end

  // State, page and all outputs update on the same edge so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SHOW;
      page_sel  <= RESET_SEL;
      target    <= RESET_SEL;
      frame_cnt <= '0;
      page_en   <= RESET_EN;
      blank     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      page_sel  <= page_n;
      target    <= target_n;
      frame_cnt <= cnt_n;
      page_en   <= page_en_n;
      blank     <= blank_n;
      busy      <= busy_n;
    end
  end

endmodule
